// File: rtl/game_controller.sv
// game_controller: top-level sequencer for the 16x16 LED Flappy Bird game.
// Runs the IDLE/PLAY/OVER state machine, divides the system clock into game
// ticks, moves the bird in lane 11 (gravity and flap) and keeps the score.
// Every output is a register; no input reaches an output combinationally.
module game_controller #(
   parameter int unsigned TICK_DIV  = 12_500_000,  // clock cycles per game tick (>= 2)
   parameter int unsigned START_POS = 8,           // bird position loaded on entry to IDLE
   parameter int unsigned FLAP_STEP = 3,           // positions gained per flap
   parameter int unsigned LOCKOUT   = 2            // ticks in OVER before a restart flap counts
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flap,
   input  logic       dead,
   input  logic       pipe_pass,
   output logic [1:0] state,
   output logic [3:0] bird_pos,
   output logic [7:0] score,
   output logic       scroll_en,
   output logic       freeze
);

   localparam int unsigned TCNT_W = $clog2(TICK_DIV);
   localparam int unsigned LOCK_W = $clog2(LOCKOUT + 1);

   localparam logic [TCNT_W-1:0] TCNT_MAX  = TCNT_W'(TICK_DIV - 1);
   localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCKOUT);
   localparam logic [3:0]        START_VAL = 4'(START_POS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_t;

   state_t            st;
   logic [TCNT_W-1:0] tcnt;
   logic [LOCK_W-1:0] lockout;
   logic              flap_q;
   logic              flap_e;
   logic              tick;
   logic [4:0]        flap_sum;
   logic [3:0]        flap_pos;

   // Rising edge of the (already debounced) button. flap_q resets high so a
   // button held through reset must be released before it can start a game.
   assign flap_e = flap & ~flap_q;

   // tcnt sits at 0 in IDLE, so tick can only fire in PLAY or OVER.
   assign tick = (tcnt == TCNT_MAX);

   // Flap target, clamped at the top of the lane.
   assign flap_sum = {1'b0, bird_pos} + 5'(FLAP_STEP);
   assign flap_pos = flap_sum[4] ? 4'd15 : flap_sum[3:0];

   assign state = st;

   // Game state machine: state, counters and all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st        <= IDLE;
         bird_pos  <= START_VAL;
         score     <= 8'd0;
         scroll_en <= 1'b0;
         freeze    <= 1'b1;
         tcnt      <= '0;
         lockout   <= '0;
         flap_q    <= 1'b1;
      end else begin
         // NOTE: every register here uses <= so all branches see the values
         // from before this edge; the default below is overridden later in
         // the same block only when a tick is actually issued.
         flap_q    <= flap;
         scroll_en <= 1'b0;

         unique case (st)
            IDLE: begin
               bird_pos <= START_VAL;
               score    <= 8'd0;
               tcnt     <= '0;
               lockout  <= '0;
               if (flap_e) begin
                  st     <= PLAY;
                  freeze <= 1'b0;
               end
            end

            PLAY: begin
               if (dead || (tick && (bird_pos == 4'd0) && !flap_e)) begin
                  // Collision or ground hit: freeze everything as it is.
                  st      <= OVER;
                  freeze  <= 1'b1;
                  tcnt    <= '0;
                  lockout <= '0;
               end else begin
                  tcnt <= tick ? '0 : tcnt + 1'b1;
                  if (flap_e) begin
                     bird_pos <= flap_pos;
                  end else if (tick) begin
                     bird_pos <= bird_pos - 4'd1;
                  end
                  if (tick) begin
                     scroll_en <= 1'b1;
                  end
                  if (pipe_pass && (score != 8'hFF)) begin
                     score <= score + 8'd1;
                  end
               end
            end

            OVER: begin
               if (flap_e && (lockout == LOCK_MAX)) begin
                  st       <= IDLE;
                  tcnt     <= '0;
                  lockout  <= '0;
                  bird_pos <= START_VAL;
                  score    <= 8'd0;
               end else begin
                  tcnt <= tick ? '0 : tcnt + 1'b1;
                  if (tick && (lockout != LOCK_MAX)) begin
                     lockout <= lockout + 1'b1;
                  end
               end
            end

            default: begin
               st     <= IDLE;
               freeze <= 1'b1;
               tcnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: directed test of game_controller with TICK_DIV=4,
// START_POS=8, FLAP_STEP=3, LOCKOUT=2. The stimulus process pushes the
// expected output vector for a given clock edge into a scoreboard queue; the
// monitor samples the outputs 1 time unit after every rising edge and checks
// each entry that is due on that edge.
module tb_game_controller;

   localparam int TICK_DIV  = 4;
   localparam int START_POS = 8;
   localparam int FLAP_STEP = 3;
   localparam int LOCKOUT   = 2;

   logic       clk       = 1'b0;
   logic       reset     = 1'b1;
   logic       flap      = 1'b0;
   logic       dead      = 1'b0;
   logic       pipe_pass = 1'b0;
   logic [1:0] state;
   logic [3:0] bird_pos;
   logic [7:0] score;
   logic       scroll_en;
   logic       freeze;

   game_controller #(
      .TICK_DIV (TICK_DIV),
      .START_POS(START_POS),
      .FLAP_STEP(FLAP_STEP),
      .LOCKOUT  (LOCKOUT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .flap     (flap),
      .dead     (dead),
      .pipe_pass(pipe_pass),
      .state    (state),
      .bird_pos (bird_pos),
      .score    (score),
      .scroll_en(scroll_en),
      .freeze   (freeze)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      string       name;
      logic [1:0]  st;
      logic [3:0]  bp;
      logic [7:0]  sc;
      logic        se;
      logic        fz;
   } exp_t;

   exp_t        sb[$];
   int unsigned ecount = 0;
   int          n_cmp  = 0;
   int          n_fail = 0;

   // Hand-computed bird positions for the flap/saturation phase (edges q+1..q+24).
   int bp3 [24] = '{8, 11, 11, 10, 13, 13, 15, 14, 15, 15, 15, 14,
                    14, 14, 14, 13, 13, 13, 13, 12, 12, 12, 12, 15};
   // Bird position and score for the score phase (edges q+25..q+31).
   int bp4 [7]  = '{15, 15, 15, 14, 14, 14, 14};
   int sc4 [7]  = '{1, 1, 2, 2, 3, 3, 3};

   task automatic push(input int unsigned c, input string n, input int st,
                       input int bp, input int sc, input int se, input int fz);
      exp_t e;
      e.cyc  = c;
      e.name = n;
      e.st   = 2'(st);
      e.bp   = 4'(bp);
      e.sc   = 8'(sc);
      e.se   = 1'(se);
      e.fz   = 1'(fz);
      sb.push_back(e);
   endtask

   task automatic check(input exp_t e);
      n_cmp++;
      if (state !== e.st || bird_pos !== e.bp || score !== e.sc ||
          scroll_en !== e.se || freeze !== e.fz) begin
         n_fail++;
         $display("FAIL %s (edge %0d): got st=%0d bp=%0d sc=%0d se=%0b fz=%0b, expected st=%0d bp=%0d sc=%0d se=%0b fz=%0b",
                  e.name, e.cyc, state, bird_pos, score, scroll_en, freeze,
                  e.st, e.bp, e.sc, e.se, e.fz);
      end
   endtask

   // Monitor: counts rising edges and checks every expectation due now.
   always begin
      exp_t e;
      @(posedge clk);
      ecount++;
      #1;
      while (sb.size() != 0 && sb[0].cyc <= ecount) begin
         e = sb.pop_front();
         if (e.cyc < ecount) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: expectation for edge %0d missed (now edge %0d)",
                     e.name, e.cyc, ecount);
         end else begin
            check(e);
         end
      end
   end

   // Wait for the falling edge that follows rising edge e.
   task automatic at(input int unsigned e);
      while (ecount < e) @(negedge clk);
   endtask

   // One-cycle flap pulse sampled high at rising edge e.
   task automatic flap_at(input int unsigned e);
      at(e - 1);
      flap = 1'b1;
      at(e);
      flap = 1'b0;
   endtask

   // One-cycle pipe_pass pulse sampled high at rising edge e.
   task automatic pp_at(input int unsigned e);
      at(e - 1);
      pipe_pass = 1'b1;
      at(e);
      pipe_pass = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned p, o, q, r, s, t, u;

      // Reset values while reset is held.
      push(1, "reset_vals", 0, 8, 0, 0, 1);
      push(2, "reset_vals", 0, 8, 0, 0, 1);
      push(4, "idle_hold", 0, 8, 0, 0, 1);
      p = 5;
      push(p, "play_entry", 1, 8, 0, 0, 0);
      // Free fall: one step per tick, scroll every 4 cycles, ground hit.
      for (int k = 1; k <= 35; k++)
         push(p + k, "fall", 1, 8 - k / 4, 0, (k % 4 == 0) ? 1 : 0, 0);
      o = p + 36;
      push(o, "ground_over", 2, 0, 0, 0, 1);
      // Lockout: flaps at o+2 and o+6 discarded, flap at o+10 restarts.
      for (int k = 1; k <= 9; k++)
         push(o + k, "over_lockout", 2, 0, 0, 0, 1);
      push(o + 10, "restart_idle", 0, 8, 0, 0, 1);
      push(o + 11, "idle_wait", 0, 8, 0, 0, 1);
      q = o + 12;
      push(q, "replay", 1, 8, 0, 0, 0);

      at(3);
      reset = 1'b0;
      flap_at(5);

      flap_at(o + 2);
      flap_at(o + 6);
      flap_at(o + 10);

      // Flap saturation and flap-on-tick phase, then scoring and dead.
      for (int k = 1; k <= 24; k++)
         push(q + k, "flap_sat", 1, bp3[k - 1], 0, (k % 4 == 0) ? 1 : 0, 0);
      for (int k = 25; k <= 31; k++)
         push(q + k, "score", 1, bp4[k - 25], sc4[k - 25], (k == 28) ? 1 : 0, 0);
      r = q + 32;
      for (int k = 0; k <= 9; k++)
         push(r + k, "dead_over", 2, 14, 3, 0, 1);
      push(r + 10, "restart2_idle", 0, 8, 0, 0, 1);
      push(r + 11, "idle_wait2", 0, 8, 0, 0, 1);
      s = r + 12;
      push(s, "replay2", 1, 8, 0, 0, 0);

      flap_at(q);
      flap_at(q + 2);
      flap_at(q + 5);
      flap_at(q + 7);
      flap_at(q + 9);
      flap_at(q + 11);
      flap_at(q + 24);
      pp_at(q + 25);
      pp_at(q + 27);
      pp_at(q + 29);
      at(q + 31);
      dead      = 1'b1;
      pipe_pass = 1'b1;
      at(q + 32);
      dead      = 1'b0;
      pipe_pass = 1'b0;
      pp_at(q + 34);
      flap_at(r + 10);
      flap_at(r + 12);

      // Score saturation: pipe_pass held high, flap toggled every cycle.
      push(s + 1, "sat_score", 1, 8, 1, 0, 0);
      push(s + 2, "sat_score", 1, 11, 2, 0, 0);
      push(s + 4, "sat_score", 1, 14, 4, 1, 0);
      push(s + 128, "sat_score", 1, 15, 128, 1, 0);
      push(s + 254, "sat_score", 1, 15, 254, 0, 0);
      push(s + 255, "sat_score", 1, 15, 255, 0, 0);
      push(s + 256, "sat_score", 1, 15, 255, 1, 0);
      push(s + 257, "sat_score", 1, 15, 255, 0, 0);
      push(s + 260, "sat_score", 1, 15, 255, 1, 0);
      pipe_pass = 1'b1;
      for (int k = 1; k <= 259; k++) begin
         at(s + k);
         flap = ~flap;
      end
      at(s + 260);
      pipe_pass = 1'b0;
      flap      = 1'b1;

      // Short reset pulse mid-PLAY with the button held down.
      t = s + 262;
      for (int k = 1; k <= 5; k++)
         push(t + k, "reset_held_flap", 0, 8, 0, 0, 1);
      u = t + 6;
      push(u, "play_after_release", 1, 8, 0, 0, 0);
      for (int k = 1; k <= 10; k++)
         push(u + k, "score5", 1, (k < 4) ? 8 : ((k < 8) ? 7 : 6),
              (k + 1) / 2, (k % 4 == 0) ? 1 : 0, 0);
      push(u + 11, "reset_mid_play", 0, 8, 0, 0, 1);
      push(u + 12, "reset_mid_play", 0, 8, 0, 0, 1);

      at(t);
      reset = 1'b1;
      #2;
      reset = 1'b0;
      at(t + 4);
      flap = 1'b0;
      flap_at(t + 6);
      pp_at(u + 1);
      pp_at(u + 3);
      pp_at(u + 5);
      pp_at(u + 7);
      pp_at(u + 9);
      at(u + 10);
      reset = 1'b1;
      #2;
      reset = 1'b0;

      at(u + 14);
      while (sb.size() != 0) begin
         exp_t e;
         e = sb.pop_front();
         n_cmp++;
         n_fail++;
         $display("FAIL %s: expectation for edge %0d never checked", e.name, e.cyc);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/game_controller.md
# game_controller

Top-level sequencer for the 16x16 LED Flappy Bird game. It runs the IDLE/PLAY/OVER state machine and generates the scroll tick that advances the pipe field. It also owns the bird's vertical position in lane 11 (gravity and flap) and keeps the score. It consumes the collision flag from the lane-11 red/green overlap checker and the pipe-pass pulse from the pipe generator, and drives the bird renderer and the pipe scroller.

## Interface
- TICK_DIV, 12_500_000, clock cycles per game tick (≥2)
- START_POS, 8, bird position loaded on entry to IDLE (0..15)
- FLAP_STEP, 3, positions gained per flap (1..15)
- LOCKOUT, 2, ticks spent in OVER before a restart flap is accepted (≥1)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- flap  in  1  player button, already synchronized/debounced, level
- dead  in  1  collision flag from overlap checker (red & green anywhere in lane 11)
- pipe_pass  in  1  one-cycle pulse when a pipe gap clears the bird lane
- state  out  2  0=IDLE, 1=PLAY, 2=OVER (3 unused, never driven)
- bird_pos  out  4  bird index within lane 11; 15 = top, 0 = ground
- score  out  8  pipes passed, binary, saturating
- scroll_en  out  1  one-cycle pulse per tick, PLAY only
- freeze  out  1  high when not in PLAY; scroller/generator hold

## Operation
- Flap edge: flap_e = flap & ~flap_q, where flap_q is a registered copy of flap. flap_q resets to 1, so a button held through reset needs a release first.
- Tick counter tcnt: width $clog2(TICK_DIV). It counts 0..TICK_DIV-1 in PLAY and OVER, and is held at 0 in IDLE. tick = (tcnt == TICK_DIV-1). It wraps to 0 on tick and clears to 0 on every state change.
- IDLE: bird_pos = START_POS, score = 0, freeze = 1, scroll_en = 0. dead and pipe_pass are ignored. flap_e moves to PLAY.
- PLAY, with priority top-down in any cycle:
  - dead = 1: go to OVER. Nothing else updates that cycle: no score or bird_pos change, and scroll_en = 0.
  - tick with bird_pos == 0 and no flap_e: go to OVER (ground hit). bird_pos stays 0.
  - Otherwise, all of the following apply in parallel:
    - flap_e: bird_pos = min(bird_pos + FLAP_STEP, 15).
    - tick without flap_e: bird_pos -= 1 (gravity). When flap_e and tick coincide, the flap wins and gravity is skipped for that tick.
    - tick: scroll_en = 1 for that cycle, independent of flap.
    - pipe_pass: score = min(score + 1, 255).
- OVER: freeze = 1, scroll_en = 0. bird_pos and score are held; dead and pipe_pass are ignored.
  - A lockout counter counts ticks in OVER and saturates at LOCKOUT.
  - flap_e while lockout < LOCKOUT is discarded.
  - flap_e once lockout == LOCKOUT moves to IDLE, which reloads bird_pos = START_POS and score = 0 on entry.
- Reset mid-game: returns immediately to the reset values below. No partial state survives.

## Timing
- All outputs are registered, and no input reaches an output combinationally.
- Reset values:
  - state = IDLE, bird_pos = START_POS, score = 0
  - scroll_en = 0, freeze = 1
  - tcnt = 0, lockout = 0, flap_q = 1
- Latency is one cycle for every transition:
  - Input condition at edge n shows on state/bird_pos/score after edge n+1.
  - freeze tracks state in the same cycle: it is decoded from the registered next state and registered alongside it.
- scroll_en:
  - It is high for exactly one cycle, registered with the tick that produced it.
  - Period is TICK_DIV cycles in steady PLAY.
  - The first pulse comes TICK_DIV cycles after the PLAY entry edge.
- dead during a tick cycle: OVER is taken, no scroll_en pulse is issued, and there is no gravity step.
- pipe_pass with dead in the same cycle: the score is not incremented.
- Score at 255 plus pipe_pass: stays 255.
- bird_pos at 15 plus flap: stays 15.
- bird_pos 14 plus FLAP_STEP 3: result is 15.

## Test plan
- Reset, then a flap pulse (low→high) → state = 1 after the next edge, bird_pos = 8, and the first scroll_en comes TICK_DIV cycles later. Run with TICK_DIV = 4: scroll_en every 4 cycles.
- PLAY, no flaps, TICK_DIV = 4, START_POS = 8 → bird_pos steps 8,7,...,0 on successive ticks. The tick after reaching 0 gives state = 2, bird_pos = 0, and scroll_en stays 0 thereafter.
- PLAY at bird_pos = 14: flap → 15; flap again → 15. Then flap and tick in the same cycle → bird_pos rises by 3 (saturating), there is no decrement, and scroll_en pulses.
- PLAY: 3 pipe_pass pulses → score = 3. Then dead and pipe_pass in the same cycle → state = 2, score stays 3. Force score to 255 and pulse pipe_pass → 255.
- OVER with LOCKOUT = 2: flap before 2 ticks → stays 2. Flap after 2 ticks → state = 0, bird_pos = 8, score = 0. Next flap → state = 1.
- flap held high through reset release → no PLAY entry until flap drops and rises again. Assert reset mid-PLAY at score = 5 → all outputs return to their reset values within the same cycle.
